// File: rtl/pipe_mem_stage.sv
// -----------------------------------------------------------------------------
// pipe_mem_stage
//   MEM stage of the 5-stage pipeline. Takes the EX/MEM register outputs and
//   runs loads and stores against a variable-latency data RAM. It stalls the
//   upstream stages while an access is outstanding and drives the MEM/WB
//   register that the WB stage reads.
//
// Ports
//   clk, resetn              rising-edge clock, asynchronous active-low reset
//   mwreg, mm2reg, mwmem     EX/MEM control: reg write, load, store
//   malu, mb, mrn            EX/MEM ALU result / byte address, store data, rd
//   mem_req, mem_we          registered RAM request and write flag
//   mem_addr, mem_wdata      registered word address and write data
//   mem_rdata, mem_ack       RAM read data and single-cycle completion pulse
//   stall                    combinational freeze of PC, IF/ID, ID/EX, EX/MEM
//   wwreg, wm2reg, wmo,      MEM/WB register outputs
//   walu, wrn
//   err                      sticky fault: RAM timeout or misaligned access
//   dbg_state                current FSM state (0 IDLE, 1 ACC, 2 DONE)
//
// RAM handshake: mem_req rises with mem_we/mem_addr/mem_wdata and all four
// hold steady until the RAM returns a one-cycle mem_ack (or the timeout
// expires). mem_rdata is valid only in the mem_ack cycle. The RAM has to
// tolerate a request that is dropped by reset or timeout before it acks.
//
// Optional build macro PIPE_MEM_WBUF_EN adds a one-entry posted write buffer.
// Stores then retire without a stall and drain in the background. Any later
// load or store waits in IDLE until the drain completes.
// -----------------------------------------------------------------------------
module pipe_mem_stage #(
    parameter int AW      = 10,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic          mwmem,
    input  logic [31:0]   malu,
    input  logic [31:0]   mb,
    input  logic [4:0]    mrn,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          stall,
    output logic          wwreg,
    output logic          wm2reg,
    output logic [31:0]   wmo,
    output logic [31:0]   walu,
    output logic [4:0]    wrn,
    output logic          err,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          aborted_q, aborted_d;
    logic          err_q, err_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          wwreg_q, wwreg_d;
    logic          wm2reg_q, wm2reg_d;
    logic [31:0]   wmo_q, wmo_d;
    logic [31:0]   walu_q, walu_d;
    logic [4:0]    wrn_q, wrn_d;
    logic          wbuf_valid_q, wbuf_valid_d;

    logic is_mem, misalign, acc, timeout_hit, stall_c;

    always_comb begin
        is_mem      = mm2reg | mwmem;
        misalign    = is_mem & (malu[1:0] != 2'b00);
        acc         = is_mem & (malu[1:0] == 2'b00);
        timeout_hit = (cnt_q == TO_LAST);

        state_d      = state_q;
        cnt_d        = cnt_q;
        aborted_d    = aborted_q;
        err_d        = err_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        wwreg_d      = wwreg_q;
        wm2reg_d     = wm2reg_q;
        wmo_d        = wmo_q;
        walu_d       = walu_q;
        wrn_d        = wrn_q;
        wbuf_valid_d = wbuf_valid_q;
        stall_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
`ifdef PIPE_MEM_WBUF_EN
                // Background drain of the posted store; shares the RAM port.
                if (wbuf_valid_q) begin
                    if (mem_ack) begin
                        mem_req_d    = 1'b0;
                        wbuf_valid_d = 1'b0;
                    end else if (timeout_hit) begin
                        mem_req_d    = 1'b0;
                        wbuf_valid_d = 1'b0;
                        err_d        = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                if (acc && wbuf_valid_q) begin
                    // Any memory op waits for the drain; WB sees bubbles.
                    stall_c  = 1'b1;
                    wwreg_d  = 1'b0;
                    wm2reg_d = 1'b0;
                end else if (acc && mwmem) begin
                    // Post the store and retire it like an ALU instruction.
                    wbuf_valid_d = 1'b1;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b1;
                    mem_addr_d   = malu[AW+1:2];
                    mem_wdata_d  = mb;
                    cnt_d        = 8'd0;
                    wwreg_d      = mwreg;
                    wm2reg_d     = mm2reg;
                    walu_d       = malu;
                    wrn_d        = mrn;
                    wmo_d        = 32'd0;
                end else
`endif
                if (acc) begin
                    stall_c     = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = mwmem;  // load+store together counts as a store
                    mem_addr_d  = malu[AW+1:2];
                    mem_wdata_d = mb;
                    cnt_d       = 8'd0;
                    aborted_d   = 1'b0;
                    wwreg_d     = 1'b0;
                    wm2reg_d    = 1'b0;
                    wmo_d       = 32'd0;
                    state_d     = S_ACC;
                end else begin
                    // Non-memory op retires next edge; misaligned op retires as a bubble.
                    wwreg_d  = mwreg & ~misalign;
                    wm2reg_d = mm2reg & ~misalign;
                    walu_d   = malu;
                    wrn_d    = mrn;
                    wmo_d    = 32'd0;
                    if (misalign) err_d = 1'b1;
                end
            end
            S_ACC: begin
                stall_c  = 1'b1;
                wwreg_d  = 1'b0;
                wm2reg_d = 1'b0;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) wmo_d = mem_rdata;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                // The instruction is still held on the EX/MEM outputs here.
                wwreg_d  = mwreg & ~aborted_q;
                wm2reg_d = mm2reg;
                walu_d   = malu;
                wrn_d    = mrn;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            aborted_q    <= 1'b0;
            err_q        <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            wwreg_q      <= 1'b0;
            wm2reg_q     <= 1'b0;
            wmo_q        <= 32'd0;
            walu_q       <= 32'd0;
            wrn_q        <= 5'd0;
            wbuf_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            aborted_q    <= aborted_d;
            err_q        <= err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            wwreg_q      <= wwreg_d;
            wm2reg_q     <= wm2reg_d;
            wmo_q        <= wmo_d;
            walu_q       <= walu_d;
            wrn_q        <= wrn_d;
            wbuf_valid_q <= wbuf_valid_d;
        end
    end

    // Gated by resetn so a held memory op cannot stall the pipe during reset.
    assign stall     = stall_c & resetn;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wwreg     = wwreg_q;
    assign wm2reg    = wm2reg_q;
    assign wmo       = wmo_q;
    assign walu      = walu_q;
    assign wrn       = wrn_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
module tb_pipe_mem_stage;
  localparam int AW = 10;
  localparam int TIMEOUT = 16;

  logic          clk, resetn;
  logic          mwreg, mm2reg, mwmem;
  logic [31:0]   malu, mb;
  logic [4:0]    mrn;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_ack;
  logic          stall, wwreg, wm2reg, err;
  logic [31:0]   wmo, walu;
  logic [4:0]    wrn;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_mem_stage #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .malu(malu), .mb(mb), .mrn(mrn),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo),
    .walu(walu), .wrn(wrn), .err(err), .dbg_state(dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: expected values are queued, then popped against the DUT
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expected value queued (actual %h)", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: actual %h required %h", name, act, e);
      end
    end
  endtask

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] e);
    exp_q.push_back(e);
    chk(name, act);
  endtask

  // driver tasks
  task automatic drive(input logic wreg, input logic m2reg, input logic wmem,
                       input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn);
    mwreg = wreg; mm2reg = m2reg; mwmem = wmem; malu = alu; mb = b; mrn = rn;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  // one clock: outputs are sampled at the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    nop();
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic        wreg, m2reg, wmem;
    logic [31:0] alu, b;
    logic [4:0]  rn;
    logic        e_stall, e_wwreg, e_wm2reg;
    logic [31:0] e_walu;
    logic [4:0]  e_wrn;
    logic        e_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // single-cycle vectors: non-memory ops, then misaligned ops (err is sticky)
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 5'd5,  1'b0, 1'b1, 1'b0, 32'h0000_0010, 5'd5,  1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1, 5'd31, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 5'd31, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0000_0003, 32'h0, 5'd0,  1'b0, 1'b0, 1'b0, 32'h0000_0003, 5'd0,  1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h1234_5671, 32'h0, 5'd7,  1'b0, 1'b1, 1'b0, 32'h1234_5671, 5'd7,  1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0042, 32'h0, 5'd3,  1'b0, 1'b0, 1'b0, 32'h0000_0042, 5'd3,  1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_0101, 32'h55, 5'd2, 1'b0, 1'b0, 1'b0, 32'h0000_0101, 5'd2,  1'b1};

    resetn = 1'b0;
    nop();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    #1;
    // reset state
    expect_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    expect_eq("rst_stall", {31'd0, stall}, 32'd0);
    expect_eq("rst_wwreg", {31'd0, wwreg}, 32'd0);
    expect_eq("rst_walu", walu, 32'd0);
    expect_eq("rst_err", {31'd0, err}, 32'd0);
    expect_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // table-driven single-cycle vectors
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].wreg, vecs[i].m2reg, vecs[i].wmem, vecs[i].alu, vecs[i].b, vecs[i].rn);
      #1;
      expect_eq($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
      @(negedge clk);
      expect_eq($sformatf("v%0d_wwreg", i), {31'd0, wwreg}, {31'd0, vecs[i].e_wwreg});
      expect_eq($sformatf("v%0d_wm2reg", i), {31'd0, wm2reg}, {31'd0, vecs[i].e_wm2reg});
      expect_eq($sformatf("v%0d_walu", i), walu, vecs[i].e_walu);
      expect_eq($sformatf("v%0d_wrn", i), {27'd0, wrn}, {27'd0, vecs[i].e_wrn});
      expect_eq($sformatf("v%0d_wmo", i), wmo, 32'd0);
      expect_eq($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].e_err});
      expect_eq($sformatf("v%0d_mem_req", i), {31'd0, mem_req}, 32'd0);
    end
    nop();
    tick();
    expect_eq("err_sticky", {31'd0, err}, 32'd1);

    do_reset();
    #1;
    expect_eq("err_cleared", {31'd0, err}, 32'd0);

    // load with ack in the second ACC cycle
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd9);
    #1;
    expect_eq("ld_stall_idle", {31'd0, stall}, 32'd1);
    tick();
    expect_eq("ld_state_acc", {30'd0, dbg_state}, 32'd1);
    expect_eq("ld_mem_req", {31'd0, mem_req}, 32'd1);
    expect_eq("ld_mem_we", {31'd0, mem_we}, 32'd0);
    expect_eq("ld_mem_addr", {22'd0, mem_addr}, 32'h010);
    expect_eq("ld_stall_acc1", {31'd0, stall}, 32'd1);
    expect_eq("ld_bubble", {31'd0, wwreg}, 32'd0);
    tick();
    expect_eq("ld_stall_acc2", {31'd0, stall}, 32'd1);
    expect_eq("ld_req_held", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    expect_eq("ld_stall_done", {31'd0, stall}, 32'd0);
    expect_eq("ld_req_drop", {31'd0, mem_req}, 32'd0);
    expect_eq("ld_wmo_cap", wmo, 32'hCAFE_F00D);
    tick();
    expect_eq("ld_wwreg", {31'd0, wwreg}, 32'd1);
    expect_eq("ld_wm2reg", {31'd0, wm2reg}, 32'd1);
    expect_eq("ld_wmo", wmo, 32'hCAFE_F00D);
    expect_eq("ld_walu", walu, 32'h0000_0040);
    expect_eq("ld_wrn", {27'd0, wrn}, 32'd9);
    expect_eq("ld_state_idle", {30'd0, dbg_state}, 32'd0);
    nop();
    tick();

`ifndef PIPE_MEM_WBUF_EN
    // blocking store, immediate ack
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 5'd0);
    #1;
    expect_eq("st_stall_idle", {31'd0, stall}, 32'd1);
    tick();
    expect_eq("st_mem_req", {31'd0, mem_req}, 32'd1);
    expect_eq("st_mem_we", {31'd0, mem_we}, 32'd1);
    expect_eq("st_mem_addr", {22'd0, mem_addr}, 32'd2);
    expect_eq("st_mem_wdata", mem_wdata, 32'h1234_5678);
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    expect_eq("st_stall_done", {31'd0, stall}, 32'd0);
    expect_eq("st_req_drop", {31'd0, mem_req}, 32'd0);
    expect_eq("st_wmo_zero", wmo, 32'd0);
    tick();
    expect_eq("st_wwreg", {31'd0, wwreg}, 32'd0);
    expect_eq("st_walu", walu, 32'h0000_0008);
`else
    // posted store, then a load that must wait for the drain ack
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 5'd0);
    #1;
    expect_eq("wb_st_stall", {31'd0, stall}, 32'd0);
    tick();
    expect_eq("wb_mem_req", {31'd0, mem_req}, 32'd1);
    expect_eq("wb_mem_we", {31'd0, mem_we}, 32'd1);
    expect_eq("wb_mem_addr", {22'd0, mem_addr}, 32'd2);
    expect_eq("wb_mem_wdata", mem_wdata, 32'h1234_5678);
    expect_eq("wb_st_wwreg", {31'd0, wwreg}, 32'd0);
    expect_eq("wb_st_walu", walu, 32'h0000_0008);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd4);
    #1;
    expect_eq("wb_ld_stall0", {31'd0, stall}, 32'd1);
    tick();
    expect_eq("wb_ld_stall1", {31'd0, stall}, 32'd1);
    expect_eq("wb_drain_held", {31'd0, mem_we}, 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    expect_eq("wb_drain_done", {31'd0, mem_req}, 32'd0);
    expect_eq("wb_ld_stall2", {31'd0, stall}, 32'd1);
    tick();
    expect_eq("wb_ld_req", {31'd0, mem_req}, 32'd1);
    expect_eq("wb_ld_we", {31'd0, mem_we}, 32'd0);
    expect_eq("wb_ld_addr", {22'd0, mem_addr}, 32'h010);
    mem_ack = 1'b1;
    mem_rdata = 32'h0BAD_CAFE;
    tick();
    mem_ack = 1'b0;
    expect_eq("wb_ld_wmo", wmo, 32'h0BAD_CAFE);
    tick();
    expect_eq("wb_ld_wwreg", {31'd0, wwreg}, 32'd1);
    expect_eq("wb_ld_wrn", {27'd0, wrn}, 32'd4);
`endif
    nop();
    tick();

    // load with no ack: abort after TIMEOUT ACC cycles
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 5'd6);
    tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      expect_eq($sformatf("to_req_c%0d", i), {31'd0, mem_req}, 32'd1);
      tick();
    end
    expect_eq("to_req_drop", {31'd0, mem_req}, 32'd0);
    expect_eq("to_err", {31'd0, err}, 32'd1);
    expect_eq("to_stall_done", {31'd0, stall}, 32'd0);
    tick();
    expect_eq("to_wwreg", {31'd0, wwreg}, 32'd0);
    expect_eq("to_walu", walu, 32'h0000_0080);
    nop();
    tick();
    expect_eq("to_err_sticky", {31'd0, err}, 32'd1);

    // asynchronous reset in the middle of an access
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 5'd1);
    tick();
    expect_eq("mr_req_pre", {31'd0, mem_req}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    expect_eq("mr_mem_req", {31'd0, mem_req}, 32'd0);
    expect_eq("mr_stall", {31'd0, stall}, 32'd0);
    expect_eq("mr_wwreg", {31'd0, wwreg}, 32'd0);
    expect_eq("mr_err", {31'd0, err}, 32'd0);
    expect_eq("mr_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    nop();
    resetn = 1'b1;
    tick();
    expect_eq("mr_after_req", {31'd0, mem_req}, 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required finish");
    $fatal(1);
  end
endmodule

// File: doc/pipe_mem_stage.md
Name: pipe_mem_stage

Overview:
- MEM-stage responder for the EX/MEM pipeline register outputs (mwreg, mm2reg, mwmem, malu, mb, mrn).
- Executes loads and stores against a variable-latency data RAM through a req/ack handshake.
- Stalls upstream stages while an access is outstanding, and drives the MEM/WB pipeline register outputs consumed by the WB stage.

Parameters:
- AW, 10, data-RAM word-address width; byte address bits malu[AW+1:2] are used.
- TIMEOUT, 16, maximum wait cycles in ACC before abort (range 1..255).

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- mwreg  input  1  instruction writes the register file.
- mm2reg  input  1  instruction is a load.
- mwmem  input  1  instruction is a store.
- malu  input  32  ALU result; byte address for loads and stores.
- mb  input  32  store data.
- mrn  input  5  destination register number.
- mem_req  output  1  RAM request, registered.
- mem_we  output  1  request is a write.
- mem_addr  output  AW  word address.
- mem_wdata  output  32  write data.
- mem_rdata  input  32  read data; valid when mem_ack=1.
- mem_ack  input  1  single-cycle completion pulse.
- stall  output  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM while high.
- wwreg  output  1  MEM/WB register write enable.
- wm2reg  output  1  MEM/WB select-memory-data flag.
- wmo  output  32  MEM/WB load data.
- walu  output  32  MEM/WB ALU result.
- wrn  output  5  MEM/WB destination register.
- err  output  1  sticky fault flag: timeout or misaligned access.

Behaviour:
- Reset (resetn=0, asynchronous): all registered outputs 0; state IDLE; timeout counter 0; err 0.
- Access condition: acc = (mm2reg|mwmem) & (malu[1:0]==0). If mwmem=mm2reg=1, the access is a store; no error is raised.
- FSM states: IDLE, ACC, DONE.
- IDLE, no access:
  - stall=0.
  - At the clock edge: wwreg<=mwreg, wm2reg<=mm2reg, walu<=malu, wrn<=mrn, wmo<=0.
  - Non-memory instructions therefore have 1-cycle latency and no bubble.
- IDLE, misaligned access ((mm2reg|mwmem) & malu[1:0]!=0):
  - No RAM request; err<=1.
  - Instruction retires as a bubble: wwreg<=0, wm2reg<=0. stall=0.
- IDLE, acc=1:
  - stall=1.
  - At the clock edge: mem_req<=1, mem_we<=mwmem, mem_addr<=malu[AW+1:2], mem_wdata<=mb; counter<=0; go to ACC.
  - MEM/WB register loads a bubble: wwreg<=0.
- ACC:
  - stall=1; mem_req, mem_we, mem_addr and mem_wdata held stable.
  - Each cycle without ack: counter+1, and MEM/WB keeps receiving bubbles.
  - On mem_ack=1: mem_req<=0, capture wmo<=mem_rdata (loads only; stores leave wmo=0), go to DONE.
  - If counter reaches TIMEOUT-1 without ack: mem_req<=0, err<=1, go to DONE with the load marked aborted.
- DONE:
  - stall=0.
  - At the clock edge: wwreg<=mwreg (forced 0 if aborted), wm2reg<=mm2reg, walu<=malu, wrn<=mrn; go to IDLE.
- Load/store latency: with ack in the first ACC cycle, the instruction occupies 3 cycles (IDLE, ACC, DONE), and WB data appears on the DONE edge.
- mem_ack while in IDLE or DONE: ignored.
- A mid-access reset drops mem_req immediately. The RAM must tolerate an abandoned request.
- err stays at 1 until reset.

Optional Feature:
- Macro: PIPE_MEM_WBUF_EN.
- Defined:
  - A 1-entry posted write buffer (valid, addr, data) is added.
  - A store in IDLE with the buffer empty loads the buffer with no stall, retires next edge like a non-memory instruction, and drains via mem_req/mem_we=1 in the background.
  - Any load or store arriving while the buffer is valid stalls in IDLE until the drain ack.
  - Timeout during a drain sets err and discards the entry.
- Undefined: stores use the blocking ACC path above.

Test Plan:
- Non-memory stream: mwreg=1, malu=32'h0000_0010, mrn=5 -> stall=0 throughout; next edge wwreg=1, walu=32'h10, wrn=5.
- Load, malu=32'h0000_0040, ack after 2 ACC cycles with rdata=32'hCAFE_F00D -> mem_addr=10'h010, mem_we=0; stall high 3 cycles; DONE edge gives wwreg=1, wm2reg=1, wmo=32'hCAFEF00D.
- Store, malu=32'h0000_0008, mb=32'h1234_5678, immediate ack -> mem_we=1, mem_addr=2, mem_wdata=32'h12345678; wwreg=0 at retire.
- Load with no ack, TIMEOUT=16 -> mem_req drops after 16 ACC cycles; err=1 and stays high; retired wwreg=0.
- Misaligned load, malu=32'h0000_0042 -> no mem_req; err=1; stall=0; bubble retired.
- resetn pulsed low mid-ACC -> mem_req, stall, wwreg and err all 0 asynchronously; state IDLE. With PIPE_MEM_WBUF_EN defined, a store followed by a load stalls the load until the store ack.
